// File: rtl/mkio_pkg.sv
// mkio_pkg: shared MKIO transmit-read FSM states, word limit and parity helper
package mkio_pkg;
   typedef enum logic [2:0] {IDLE, FETCH, LOAD, SEND, DONE} tx_rd_state_t;
   localparam int MKIO_MAX_WORDS = 32;
   // Zero-extension leaves odd parity unchanged, so any word width up to 64 fits
   function automatic logic odd_parity(input logic [63:0] d);
      return ~^d;
   endfunction
endpackage

// File: rtl/mem_tx_reader.sv
// mem_tx_reader: streams word_cnt words from the subaddress RAM's registered read port to the MKIO encoder.
// Defining MKIO_TX_PARITY_EN adds a registered odd-parity output tx_parity alongside tx_data.
module mem_tx_reader
   import mkio_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 5,
   parameter int CNT_WIDTH  = $clog2(MKIO_MAX_WORDS)
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] start_addr,
   input  logic [CNT_WIDTH-1:0]  word_cnt,
   input  logic                  abort,
   output logic [ADDR_WIDTH-1:0] rdaddress,
   input  logic [DATA_WIDTH-1:0] q,
   output logic [DATA_WIDTH-1:0] tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic                  tx_last,
`ifdef MKIO_TX_PARITY_EN
   output logic                  tx_parity,
`endif
   output logic                  busy,
   output logic                  done
);
   localparam logic [CNT_WIDTH:0] max_words = {1'b1, {CNT_WIDTH{1'b0}}};
   localparam logic [CNT_WIDTH:0] one_word  = {{CNT_WIDTH{1'b0}}, 1'b1};
   tx_rd_state_t state;
   logic [CNT_WIDTH:0] remaining;
   assign busy = state != IDLE;
   assign done = state == DONE;
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         rdaddress <= '0;
         remaining <= '0;
         tx_data   <= '0;
         tx_valid  <= 1'b0;
         tx_last   <= 1'b0;
`ifdef MKIO_TX_PARITY_EN
         tx_parity <= 1'b0;
`endif
      end else if (abort && state != IDLE) begin
         state    <= IDLE;
         tx_valid <= 1'b0;
         tx_last  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               rdaddress <= start_addr;
               remaining <= word_cnt == '0 ? max_words : {1'b0, word_cnt};
               state     <= FETCH;
            end
            FETCH: state <= LOAD;
            LOAD: begin
               tx_data   <= q;
               tx_valid  <= 1'b1;
               tx_last   <= remaining == one_word;
`ifdef MKIO_TX_PARITY_EN
               tx_parity <= odd_parity(64'(q));
`endif
               // Prefetch the next word while this one waits for the encoder
               rdaddress <= rdaddress + ADDR_WIDTH'(1);
               state     <= SEND;
            end
            SEND: if (tx_ready) begin
               remaining <= remaining - one_word;
               tx_valid  <= 1'b0;
               tx_last   <= 1'b0;
               state     <= remaining == one_word ? DONE : LOAD;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_tx_reader.sv
// tb_mem_tx_reader: randomized self-checking bench for mem_tx_reader with a behavioural RAM and word-list model.
// Build with MKIO_TX_PARITY_EN defined to also exercise tx_parity.
module tb_mem_tx_reader;
   localparam int AW = 5;
   localparam int CW = 5;
   logic clock = 0, reset_n = 0, start = 0, abort = 0, tx_ready = 0;
   logic [AW-1:0] start_addr = '0;
   logic [CW-1:0] word_cnt = '0;
   logic [AW-1:0] rdaddress;
   logic [15:0] q, tx_data;
   logic tx_valid, tx_last, busy, done;
`ifdef MKIO_TX_PARITY_EN
   logic tx_parity;
   bit pars[$];
`endif
   logic [15:0] ram [32];
   logic [15:0] got[$];
   bit lasts[$];
   int first_k, done_k, done_pulses, unstable, timeout;
   int checks = 0, failures = 0;

   mem_tx_reader dut (
      .clock(clock), .reset_n(reset_n), .start(start), .start_addr(start_addr),
      .word_cnt(word_cnt), .abort(abort), .rdaddress(rdaddress), .q(q),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last),
`ifdef MKIO_TX_PARITY_EN
      .tx_parity(tx_parity),
`endif
      .busy(busy), .done(done)
   );

   always #5 clock = ~clock;
   always @(posedge clock) q <= ram[rdaddress];

   // Runs one transfer; k counts cycles after the start cycle N (negedge k lies in cycle N+k)
   task automatic xfer(input int addr, input int cnt, input int duty, input int abort_after,
                       input bit start_busy, input bit abort_with_start);
      logic [15:0] pd = '0;
      bit pl = 0, hold = 0;
      int hs = 0;
      got.delete(); lasts.delete();
`ifdef MKIO_TX_PARITY_EN
      pars.delete();
`endif
      first_k = -1; done_k = -1; done_pulses = 0; unstable = 0; timeout = 1;
      @(negedge clock);
      start = 1; start_addr = AW'(addr); word_cnt = CW'(cnt); abort = abort_with_start; tx_ready = 0;
      for (int k = 1; k < 400; k++) begin
         @(negedge clock);
         abort = 0;
         start = start_busy && k == 5;
         if (start) begin start_addr = 5'd20; word_cnt = 5'd1; end
         if (hold && (tx_valid !== 1'b1 || tx_data !== pd || tx_last !== pl)) unstable++;
         if (done === 1'b1) begin done_pulses++; if (done_k < 0) done_k = k; end
         if (tx_valid === 1'b1 && first_k < 0) first_k = k;
         if (done_k >= 0 && k > done_k && busy === 1'b0) begin timeout = 0; break; end
         tx_ready = $urandom_range(99) < duty;
         hold = tx_valid === 1'b1 && !tx_ready;
         pd = tx_data; pl = tx_last;
         if (tx_valid === 1'b1 && tx_ready) begin
            got.push_back(tx_data); lasts.push_back(tx_last);
`ifdef MKIO_TX_PARITY_EN
            pars.push_back(tx_parity);
`endif
            hs++;
            if (hs == abort_after) begin timeout = 0; return; end
         end
      end
      tx_ready = 0; start = 0;
   endtask

   // Mismatches between received words and the expected wrapped RAM sequence
   function automatic int seq_errors(int addr, int cnt);
      int n = cnt == 0 ? 32 : cnt;
      int e = got.size() != n ? 1 : 0;
      for (int i = 0; i < got.size() && i < n; i++) begin
         if (got[i] !== ram[(addr + i) % 32]) e++;
         if (lasts[i] !== (i == n - 1)) e++;
      end
      return e;
   endfunction

   task automatic test_reset();
      repeat (2) @(negedge clock);
      checks++;
      if ({rdaddress, tx_data, tx_valid, tx_last, busy, done} !== '0) begin
         failures++; $display("FAIL reset_held got=%h want=0", {rdaddress, tx_data, tx_valid, tx_last, busy, done});
      end
      reset_n = 1;
      @(negedge clock);
      checks++;
      if ({busy, done, tx_valid} !== 3'b000) begin
         failures++; $display("FAIL reset_release got=%b want=000", {busy, done, tx_valid});
      end
   endtask

   task automatic test_basic();
      xfer(3, 4, 100, -1, 0, 0);
      checks++;
      if (seq_errors(3, 4) !== 0 || timeout !== 0) begin
         failures++; $display("FAIL basic_seq errors=%0d timeout=%0d want 0", seq_errors(3, 4), timeout);
      end
      checks++;
      if (first_k !== 3) begin failures++; $display("FAIL basic_latency got=%0d want=3", first_k); end
      checks++;
      if (done_k !== 10 || done_pulses !== 1) begin
         failures++; $display("FAIL basic_done at=%0d pulses=%0d want at=10 pulses=1", done_k, done_pulses);
      end
   endtask

   task automatic test_max_wrap();
      xfer(30, 0, 100, -1, 0, 0);
      checks++;
      if (seq_errors(30, 0) !== 0 || timeout !== 0) begin
         failures++; $display("FAIL wrap_seq errors=%0d size=%0d want 0/32", seq_errors(30, 0), got.size());
      end
      checks++;
      if (done_k !== 66 || done_pulses !== 1 || first_k !== 3) begin
         failures++; $display("FAIL wrap_timing done=%0d pulses=%0d first=%0d want 66/1/3", done_k, done_pulses, first_k);
      end
   endtask

   task automatic test_backpressure();
      xfer(0, 3, 30, -1, 0, 0);
      checks++;
      if (seq_errors(0, 3) !== 0 || timeout !== 0) begin
         failures++; $display("FAIL bp_seq errors=%0d timeout=%0d want 0", seq_errors(0, 3), timeout);
      end
      checks++;
      if (unstable !== 0 || done_pulses !== 1) begin
         failures++; $display("FAIL bp_stable unstable=%0d pulses=%0d want 0/1", unstable, done_pulses);
      end
   endtask

   task automatic test_random();
      for (int t = 0; t < 5; t++) begin
         int a = $urandom_range(31), c = $urandom_range(31), d = $urandom_range(100, 20);
         xfer(a, c, d, -1, 0, 0);
         checks++;
         if (seq_errors(a, c) !== 0 || unstable !== 0 || done_pulses !== 1 || timeout !== 0) begin
            failures++;
            $display("FAIL random_%0d addr=%0d cnt=%0d errors=%0d unstable=%0d pulses=%0d want 0/0/1",
                     t, a, c, seq_errors(a, c), unstable, done_pulses);
         end
      end
   endtask

   task automatic test_start_busy();
      xfer(8, 6, 100, -1, 1, 0);
      checks++;
      if (seq_errors(8, 6) !== 0 || done_k !== 14 || done_pulses !== 1) begin
         failures++; $display("FAIL start_busy errors=%0d done=%0d want 0/14", seq_errors(8, 6), done_k);
      end
      xfer(5, 2, 100, -1, 0, 1);
      checks++;
      if (seq_errors(5, 2) !== 0 || timeout !== 0) begin
         failures++; $display("FAIL start_abort_idle errors=%0d want 0", seq_errors(5, 2));
      end
   endtask

   task automatic test_abort();
      int dp = 0;
      xfer(0, 8, 100, 2, 0, 0);
      @(negedge clock);
      abort = 1; tx_ready = 0;
      @(negedge clock);
      abort = 0;
      checks++;
      if (got.size() != 2 || got[0] !== ram[0] || got[1] !== ram[1]) begin
         failures++; $display("FAIL abort_prefix size=%0d want 2 words A000,A001", got.size());
      end
      checks++;
      if (tx_valid !== 1'b0 || busy !== 1'b0) begin
         failures++; $display("FAIL abort_idle valid=%b busy=%b want 0/0", tx_valid, busy);
      end
      for (int i = 0; i < 10; i++) begin
         if (done !== 1'b0) dp++;
         @(negedge clock);
      end
      checks++;
      if (dp !== 0) begin failures++; $display("FAIL abort_no_done pulses=%0d want 0", dp); end
      xfer(10, 3, 100, -1, 0, 0);
      checks++;
      if (seq_errors(10, 3) !== 0 || done_pulses !== 1) begin
         failures++; $display("FAIL abort_restart errors=%0d pulses=%0d want 0/1", seq_errors(10, 3), done_pulses);
      end
   endtask

   task automatic test_async_reset();
      @(negedge clock);
      start = 1; start_addr = 5'd4; word_cnt = 5'd5; tx_ready = 0;
      @(negedge clock);
      start = 0;
      repeat (2) @(negedge clock);
      checks++;
      if (tx_valid !== 1'b1) begin failures++; $display("FAIL async_pre valid=%b want 1", tx_valid); end
      #2 reset_n = 0;
      #1;
      checks++;
      if ({rdaddress, tx_data, tx_valid, tx_last, busy, done} !== '0) begin
         failures++; $display("FAIL async_reset got=%h want=0", {rdaddress, tx_data, tx_valid, tx_last, busy, done});
      end
      @(negedge clock);
      reset_n = 1;
      @(negedge clock);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         failures++; $display("FAIL async_release busy=%b done=%b want 0/0", busy, done);
      end
      xfer(4, 5, 100, -1, 0, 0);
      checks++;
      if (seq_errors(4, 5) !== 0 || timeout !== 0) begin
         failures++; $display("FAIL async_restart errors=%0d want 0", seq_errors(4, 5));
      end
   endtask

`ifdef MKIO_TX_PARITY_EN
   task automatic test_parity();
      ram[0] = 16'h0001; ram[1] = 16'h0003;
      xfer(0, 2, 100, -1, 0, 0);
      checks++;
      if (pars.size() != 2 || pars[0] !== 1'b0 || pars[1] !== 1'b1) begin
         failures++; $display("FAIL parity size=%0d want 2 values 0,1", pars.size());
      end
      ram[0] = 16'hA000; ram[1] = 16'hA001;
   endtask
`endif

   initial begin
      for (int i = 0; i < 32; i++) ram[i] = 16'hA000 + 16'(i);
      test_reset();
      test_basic();
      test_max_wrap();
      test_backpressure();
      test_random();
      test_start_busy();
      test_abort();
      test_async_reset();
`ifdef MKIO_TX_PARITY_EN
      test_parity();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
